phv_vlan_join: RTL and testbench

Output-side join buffer placed directly downstream of a pipeline stage. It captures the stage's `phv_out` / `phv_out_valid` and `vlan_out` / `vlan_valid_out` streams into two independent FIFOs. It pairs them in order and presents one joined PHV+VLAN beat per packet to the next consumer (next stage or deparser). It also drops PHVs whose discard flag is set and keeps packet and drop statistics.

---
 rtl/phv_vlan_join.sv | 114 +++++++++++
 tb/tb_phv_vlan_join.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/phv_vlan_join.sv
// Join buffer after a pipeline stage: pairs PHVs with VLAN IDs in arrival order,
// drops PHVs flagged for discard and counts forwarded/dropped packets.
module phv_vlan_join #(
    parameter int PHV_LEN        = 1024,
    parameter int C_VLANID_WIDTH = 12,
    parameter int DEPTH_BITS     = 3,
    parameter int SLACK          = 2,
    parameter int DISCARD_BIT    = 128
) (
    input  logic                      axis_clk,
    input  logic                      aresetn,
    input  logic [PHV_LEN-1:0]        phv_in,
    input  logic                      phv_in_valid,
    output logic                      phv_ready_out,
    input  logic [C_VLANID_WIDTH-1:0] vlan_in,
    input  logic                      vlan_in_valid,
    output logic                      vlan_ready_out,
    output logic [PHV_LEN-1:0]        phv_out,
    output logic [C_VLANID_WIDTH-1:0] vlan_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               pkt_cnt,
    output logic [31:0]               drop_cnt,
    output logic                      overflow_err
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] C_DEPTH     = (DEPTH_BITS+1)'(DEPTH);
    localparam logic [DEPTH_BITS:0] C_READY_LIM = (DEPTH_BITS+1)'(DEPTH - SLACK);

    typedef enum logic {S_IDLE, S_HEAD} state_t;

    state_t                    r_state, w_state_nxt;
    logic [PHV_LEN-1:0]        r_phv_mem  [DEPTH];
    logic [C_VLANID_WIDTH-1:0] r_vlan_mem [DEPTH];
    logic [DEPTH_BITS-1:0]     r_phv_wp, r_phv_rp, r_vlan_wp, r_vlan_rp;
    logic [DEPTH_BITS:0]       r_phv_cnt, r_vlan_cnt, w_phv_cnt_nxt, w_vlan_cnt_nxt;
    logic [31:0]               r_pkt_cnt, r_drop_cnt;
    logic                      r_ovf;
    logic                      w_pop, w_discard, w_out_valid, w_phv_push, w_vlan_push;

    assign w_discard = r_phv_mem[r_phv_rp][DISCARD_BIT];

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: ;
            S_HEAD: begin
                if (w_discard) begin
                    w_pop = 1'b1;
                end else begin
                    w_out_valid = 1'b1;
                    w_pop       = out_ready;
                end
            end
            default: ;
        endcase
        // A pop frees a slot this cycle, so a write at full is still accepted.
        w_phv_push     = phv_in_valid  && ((r_phv_cnt  < C_DEPTH) || w_pop);
        w_vlan_push    = vlan_in_valid && ((r_vlan_cnt < C_DEPTH) || w_pop);
        w_phv_cnt_nxt  = r_phv_cnt  + (DEPTH_BITS+1)'(w_phv_push)  - (DEPTH_BITS+1)'(w_pop);
        w_vlan_cnt_nxt = r_vlan_cnt + (DEPTH_BITS+1)'(w_vlan_push) - (DEPTH_BITS+1)'(w_pop);
        w_state_nxt    = ((w_phv_cnt_nxt != '0) && (w_vlan_cnt_nxt != '0)) ? S_HEAD : S_IDLE;
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state    <= S_IDLE;
            r_phv_wp   <= '0;
            r_phv_rp   <= '0;
            r_vlan_wp  <= '0;
            r_vlan_rp  <= '0;
            r_phv_cnt  <= '0;
            r_vlan_cnt <= '0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_phv_cnt  <= w_phv_cnt_nxt;
            r_vlan_cnt <= w_vlan_cnt_nxt;
            if (w_phv_push)  r_phv_wp  <= r_phv_wp + 1'b1;
            if (w_vlan_push) r_vlan_wp <= r_vlan_wp + 1'b1;
            if (w_pop) begin
                r_phv_rp  <= r_phv_rp + 1'b1;
                r_vlan_rp <= r_vlan_rp + 1'b1;
                if (w_discard) begin
                    if (r_drop_cnt != 32'hFFFF_FFFF) r_drop_cnt <= r_drop_cnt + 32'd1;
                end else begin
                    if (r_pkt_cnt != 32'hFFFF_FFFF) r_pkt_cnt <= r_pkt_cnt + 32'd1;
                end
            end
            if ((phv_in_valid && !w_phv_push) || (vlan_in_valid && !w_vlan_push))
                r_ovf <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only observed behind a nonzero count.
    always_ff @(posedge axis_clk) begin
        if (w_phv_push)  r_phv_mem[r_phv_wp]   <= phv_in;
        if (w_vlan_push) r_vlan_mem[r_vlan_wp] <= vlan_in;
    end

    assign out_valid      = w_out_valid;
    assign phv_out        = w_out_valid ? r_phv_mem[r_phv_rp]   : '0;
    assign vlan_out       = w_out_valid ? r_vlan_mem[r_vlan_rp] : '0;
    assign phv_ready_out  = (r_phv_cnt  < C_READY_LIM);
    assign vlan_ready_out = (r_vlan_cnt < C_READY_LIM);
    assign pkt_cnt        = r_pkt_cnt;
    assign drop_cnt       = r_drop_cnt;
    assign overflow_err   = r_ovf;

endmodule

// File: tb/tb_phv_vlan_join.sv
// Bench for phv_vlan_join: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_phv_vlan_join;
    localparam int PL = 1024;
    localparam int VW = 12;
    localparam int DB = 128;

    logic          axis_clk       = 1'b0;
    logic          aresetn        = 1'b0;
    logic [PL-1:0] phv_in         = '0;
    logic          phv_in_valid   = 1'b0;
    logic [VW-1:0] vlan_in        = '0;
    logic          vlan_in_valid  = 1'b0;
    logic          out_ready      = 1'b1;
    logic          phv_ready_out, vlan_ready_out, out_valid, overflow_err;
    logic [PL-1:0] phv_out;
    logic [VW-1:0] vlan_out;
    logic [31:0]   pkt_cnt, drop_cnt;

    int errors = 0;
    int checks = 0;

    phv_vlan_join dut (
        .axis_clk(axis_clk), .aresetn(aresetn),
        .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_ready_out(phv_ready_out),
        .vlan_in(vlan_in), .vlan_in_valid(vlan_in_valid), .vlan_ready_out(vlan_ready_out),
        .phv_out(phv_out), .vlan_out(vlan_out), .out_valid(out_valid), .out_ready(out_ready),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .overflow_err(overflow_err)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_phv(input string nm, input logic [PL-1:0] act, input logic [PL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got hi=%h lo=%h expected hi=%h lo=%h", nm,
                     act[PL-1:PL-32], act[63:0], exp[PL-1:PL-32], exp[63:0]);
        end
    endtask

    function automatic logic [PL-1:0] mk_phv(input logic [31:0] id, input logic d);
        logic [PL-1:0] p;
        p = '0;
        p[31:0]       = id;
        p[PL-1:PL-32] = ~id;
        p[DB]         = d;
        return p;
    endfunction

    // Reference model: two plain queues plus counters.
    logic [PL-1:0] mq_phv [$];
    logic [VW-1:0] mq_vlan[$];
    logic [31:0]   m_pkt = '0, m_drop = '0;
    logic          m_ovf = 1'b0;

    always @(negedge axis_clk) begin : cmp
        logic pair, disc, ev, pop, pp, vp;
        if (!aresetn) begin
            mq_phv.delete();
            mq_vlan.delete();
            m_pkt  = '0;
            m_drop = '0;
            m_ovf  = 1'b0;
        end
        pair = (mq_phv.size() > 0) && (mq_vlan.size() > 0);
        disc = 1'b0;
        if (pair) disc = mq_phv[0][DB];
        ev = pair && !disc;
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            chk_phv("phv_out", phv_out, mq_phv[0]);
            chk("vlan_out", 64'(vlan_out), 64'(mq_vlan[0]));
        end else begin
            chk_phv("phv_out_idle", phv_out, '0);
            chk("vlan_out_idle", 64'(vlan_out), 64'd0);
        end
        chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
        chk("phv_ready_out", 64'(phv_ready_out), 64'(mq_phv.size() < 6));
        chk("vlan_ready_out", 64'(vlan_ready_out), 64'(mq_vlan.size() < 6));
        if (aresetn) begin
            pop = pair && (disc || out_ready);
            pp  = phv_in_valid  && ((mq_phv.size()  < 8) || pop);
            vp  = vlan_in_valid && ((mq_vlan.size() < 8) || pop);
            if ((phv_in_valid && !pp) || (vlan_in_valid && !vp)) m_ovf = 1'b1;
            if (pop) begin
                if (disc) begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
                end else begin
                    if (m_pkt != 32'hFFFF_FFFF) m_pkt = m_pkt + 1;
                end
                void'(mq_phv.pop_front());
                void'(mq_vlan.pop_front());
            end
            if (pp) mq_phv.push_back(phv_in);
            if (vp) mq_vlan.push_back(vlan_in);
        end
    end

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    // Present one cycle of write strobes, then clear them.
    task automatic drive(input logic pv, input logic [31:0] pid, input logic pd,
                         input logic vv, input logic [VW-1:0] vid);
        phv_in        = mk_phv(pid, pd);
        phv_in_valid  = pv;
        vlan_in       = vid;
        vlan_in_valid = vv;
        step();
        phv_in_valid  = 1'b0;
        vlan_in_valid = 1'b0;
    endtask

    initial begin
        int beats;
        step();
        chk("rst_phv_ready", 64'(phv_ready_out), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        step();
        aresetn = 1'b1;
        step();

        // Basic pair
        out_ready = 1'b1;
        drive(1'b1, 32'hA, 1'b0, 1'b1, 12'h005);
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk_phv("basic_phv", phv_out, mk_phv(32'hA, 1'b0));
        chk("basic_vlan", 64'(vlan_out), 64'h5);
        step();
        chk("basic_pkt", 64'(pkt_cnt), 64'd1);
        step();

        // Skew: PHVs lead VLANs by six cycles
        for (int c = 0; c < 10; c++) begin
            drive(c < 3, 32'h100 + 32'(c), 1'b0, (c >= 6) && (c < 9), 12'(c - 5));
            if (c + 1 == 6) chk("skew_wait", 64'(out_valid), 64'd0);
            if ((c + 1 >= 7) && (c + 1 <= 9)) begin
                chk("skew_valid", 64'(out_valid), 64'd1);
                chk("skew_vlan", 64'(vlan_out), 64'(c + 1 - 6));
                chk("skew_phv", 64'(phv_out[31:0]), 64'(32'h100 + 32'(c + 1 - 7)));
            end
        end
        step();
        chk("skew_pkt", 64'(pkt_cnt), 64'd4);

        // Discard in the middle
        drive(1'b1, 32'h10, 1'b0, 1'b1, 12'h021);
        drive(1'b1, 32'h11, 1'b1, 1'b1, 12'h022);
        drive(1'b1, 32'h12, 1'b0, 1'b1, 12'h023);
        chk("disc_align_vlan", 64'(vlan_out), 64'h23);
        chk("disc_align_phv", 64'(phv_out[31:0]), 64'h12);
        step();
        step();
        chk("disc_pkt", 64'(pkt_cnt), 64'd6);
        chk("disc_drop", 64'(drop_cnt), 64'd1);

        // Backpressure fill
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b0, 1'b1, 12'h030 + 12'(i));
            chk("bp_phv_ready", 64'(phv_ready_out), 64'((i + 1) < 6));
            chk("bp_vlan_ready", 64'(vlan_ready_out), 64'((i + 1) < 6));
            chk("bp_hold_phv", 64'(phv_out[31:0]), 64'h200);
            chk("bp_ovf", 64'(overflow_err), 64'd0);
        end
        // Push and pop together at full
        out_ready = 1'b1;
        drive(1'b1, 32'h208, 1'b0, 1'b1, 12'h038);
        out_ready = 1'b0;
        chk("full_pp_ovf", 64'(overflow_err), 64'd0);
        chk("full_pp_ready", 64'(phv_ready_out), 64'd0);
        chk("full_pp_head", 64'(phv_out[31:0]), 64'h201);
        // Ninth write with no pop overflows
        drive(1'b1, 32'h209, 1'b0, 1'b1, 12'h039);
        chk("ovf_set", 64'(overflow_err), 64'd1);
        out_ready = 1'b1;
        beats = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) beats++;
            step();
        end
        chk("drain_beats", 64'(beats), 64'd8);
        chk("drain_pkt", 64'(pkt_cnt), 64'd15);

        // Reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b1, 12'h040 + 12'(i));
        chk("mid_valid", 64'(out_valid), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_pkt", 64'(pkt_cnt), 64'd0);
        step();
        step();
        aresetn   = 1'b1;
        out_ready = 1'b1;
        chk("post_pkt", 64'(pkt_cnt), 64'd0);
        chk("post_drop", 64'(drop_cnt), 64'd0);
        chk("post_ovf", 64'(overflow_err), 64'd0);
        chk("post_phv_ready", 64'(phv_ready_out), 64'd1);
        chk("post_vlan_ready", 64'(vlan_ready_out), 64'd1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_no_stale", 64'(out_valid), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
